// File: rtl/timer_pkg.sv
// Shared definitions for the timer/counter: mode encodings, prescale-select width
// and the sticky flag bundle.
package timer_pkg;

   localparam int CKS_W = 3;

   typedef enum logic [1:0] {
      MODE_FREE    = 2'b00,
      MODE_CMP     = 2'b01,
      MODE_ONESHOT = 2'b10
   } mode_t;

   typedef struct packed {
      logic ovf;
      logic udf;
      logic cmp;
   } timer_flags_t;

   // The unused encoding 2'b11 behaves exactly like free-run.
   function automatic mode_t decode_mode(input logic [1:0] raw);
      mode_t m;
      case (raw)
         2'b01:   m = MODE_CMP;
         2'b10:   m = MODE_ONESHOT;
         default: m = MODE_FREE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: free-running PSC_W-bit phase counter that raises tick
// once every 2^cks enabled cycles (cks saturates at PSC_W).
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PSC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load,
   input  logic [CKS_W-1:0] cks,
   output logic             tick
);

   logic [PSC_W-1:0] psc_reg;
   logic [PSC_W-1:0] psc_next;
   logic [PSC_W-1:0] mask;

   // Bit gi takes part in the phase match when it lies below the selected n;
   // any cks >= PSC_W selects every bit, which is the clamp.
   for (genvar gi = 0; gi < PSC_W; gi++) begin : g_mask
      assign mask[gi] = (cks > CKS_W'(gi));
   end

   assign tick = enable & (&(psc_reg | ~mask));

   always_comb begin
      psc_next = psc_reg;
      if (load) begin
         psc_next = '0;
      end else if (enable) begin
         psc_next = psc_reg + PSC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psc_reg <= '0;
      end else begin
         psc_reg <= psc_next;
      end
   end

endmodule

// File: rtl/timer_counter_n.sv
// WIDTH-bit up/down timer with prescaler, free-run / compare-reload / one-shot
// modes and sticky overflow, underflow and compare flags.
module timer_counter_n
   import timer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PSC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] start_value,
   input  logic             up_down,
   input  logic [1:0]       mode,
   input  logic [CKS_W-1:0] cks,
   input  logic [WIDTH-1:0] compare,
   input  logic             clr_ovf,
   input  logic             clr_udf,
   input  logic             clr_cmp,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             overflow,
   output logic             underflow,
   output logic             cmp_match,
   output logic             halted
);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   timer_flags_t     flags_reg;
   timer_flags_t     flags_next;
   timer_flags_t     event_flags;
   logic             halted_reg;
   logic             halted_next;
   logic             psc_tick;
   logic             hit;
   logic             at_max;
   logic             at_zero;
   mode_t            mode_eff;

   timer_prescaler #(
      .PSC_W (PSC_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .load   (load),
      .cks    (cks),
      .tick   (psc_tick)
   );

   assign tick     = psc_tick & ~halted_reg;
   assign mode_eff = decode_mode(mode);
   assign hit      = (count_reg == compare);
   assign at_max   = &count_reg;
   assign at_zero  = ~|count_reg;

   always_comb begin
      count_next  = count_reg;
      halted_next = halted_reg;
      event_flags = '0;
      if (load) begin
         count_next  = start_value;
         halted_next = 1'b0;
      end else if (tick) begin
         if (hit && mode_eff == MODE_CMP) begin
            count_next      = start_value;
            event_flags.cmp = 1'b1;
         end else begin
            event_flags.cmp = hit;
            if (up_down) begin
               if (at_max) begin
                  count_next      = '0;
                  event_flags.ovf = 1'b1;
               end else begin
                  count_next = count_reg + WIDTH'(1);
               end
            end else begin
               if (at_zero) begin
                  count_next      = '1;
                  event_flags.udf = 1'b1;
               end else begin
                  count_next = count_reg - WIDTH'(1);
               end
            end
         end
         // One-shot stops on its first event and parks at the reload value.
         if (mode_eff == MODE_ONESHOT && (|event_flags)) begin
            count_next  = start_value;
            halted_next = 1'b1;
         end
      end
      flags_next.ovf = (flags_reg.ovf & ~clr_ovf) | event_flags.ovf;
      flags_next.udf = (flags_reg.udf & ~clr_udf) | event_flags.udf;
      flags_next.cmp = (flags_reg.cmp & ~clr_cmp) | event_flags.cmp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= '0;
         flags_reg  <= '0;
         halted_reg <= 1'b0;
      end else begin
         count_reg  <= count_next;
         flags_reg  <= flags_next;
         halted_reg <= halted_next;
      end
   end

   assign count     = count_reg;
   assign overflow  = flags_reg.ovf;
   assign underflow = flags_reg.udf;
   assign cmp_match = flags_reg.cmp;
   assign halted    = halted_reg;

endmodule

// File: tb/tb_timer_counter_n.sv
// Scoreboard bench for timer_counter_n: directed scenarios then random stimulus,
// checked against an arithmetic reference model.
module tb_timer_counter_n;

   localparam int W    = 8;
   localparam int PW   = 4;
   localparam int MAXV = (1 << W) - 1;

   typedef struct {
      int cnt;
      bit ovf;
      bit udf;
      bit cmp;
      bit halt;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] start_value = '0;
   logic         up_down = 1'b1;
   logic [1:0]   mode = 2'b00;
   logic [2:0]   cks = 3'd0;
   logic [W-1:0] compare = '0;
   logic         clr_ovf = 1'b0;
   logic         clr_udf = 1'b0;
   logic         clr_cmp = 1'b0;
   logic [W-1:0] count;
   logic         tick;
   logic         overflow;
   logic         underflow;
   logic         cmp_match;
   logic         halted;

   int total = 0;
   int bad   = 0;

   exp_t sq[$];
   bit   tq[$];

   // reference model state
   int m_count = 0;
   bit m_ovf = 0, m_udf = 0, m_cmp = 0, m_halt = 0;
   int m_en = 0;

   timer_counter_n #(.WIDTH(W), .PSC_W(PW)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .load        (load),
      .start_value (start_value),
      .up_down     (up_down),
      .mode        (mode),
      .cks         (cks),
      .compare     (compare),
      .clr_ovf     (clr_ovf),
      .clr_udf     (clr_udf),
      .clr_cmp     (clr_cmp),
      .count       (count),
      .tick        (tick),
      .overflow    (overflow),
      .underflow   (underflow),
      .cmp_match   (cmp_match),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      int  n, p, nxt, md;
      bit  t, eo, eu, ec;
      exp_t e;
      if (rst) begin
         m_count = 0; m_ovf = 0; m_udf = 0; m_cmp = 0; m_halt = 0; m_en = 0;
      end
      n = (int'(cks) > PW) ? PW : int'(cks);
      p = 1 << n;
      t = enable && !m_halt && ((m_en % p) == p - 1);
      tq.push_back(t);
      if (!rst) begin
         eo = 0; eu = 0; ec = 0;
         if (load) begin
            m_count = int'(start_value);
            m_halt  = 0;
            m_en    = 0;
         end else begin
            if (enable) m_en++;
            if (t) begin
               md  = (mode == 2'b11) ? 0 : int'(mode);
               nxt = m_count;
               if (md == 1 && m_count == int'(compare)) begin
                  nxt = int'(start_value);
                  ec  = 1;
               end else begin
                  ec = (m_count == int'(compare));
                  if (up_down) begin
                     eo  = (m_count == MAXV);
                     nxt = (m_count + 1) % (MAXV + 1);
                  end else begin
                     eu  = (m_count == 0);
                     nxt = (m_count + MAXV) % (MAXV + 1);
                  end
               end
               if (md == 2 && (eo || eu || ec)) begin
                  nxt    = int'(start_value);
                  m_halt = 1;
               end
               m_count = nxt;
            end
         end
         m_ovf = (m_ovf && !clr_ovf) || eo;
         m_udf = (m_udf && !clr_udf) || eu;
         m_cmp = (m_cmp && !clr_cmp) || ec;
      end
      e.cnt = m_count; e.ovf = m_ovf; e.udf = m_udf; e.cmp = m_cmp; e.halt = m_halt;
      sq.push_back(e);
   endtask

   // Inputs are set by the caller at a falling edge; this applies them for one cycle.
   task automatic cyc();
      model_step();
      if (rst) begin
         #2;
         total++;
         if (count !== '0 || overflow !== 1'b0 || underflow !== 1'b0 ||
             cmp_match !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: got count=%0d ovf=%b udf=%b cmp=%b halt=%b, want all zero",
                     count, overflow, underflow, cmp_match, halted);
         end
      end
      @(negedge clk);
      load = 1'b0; clr_ovf = 1'b0; clr_udf = 1'b0; clr_cmp = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // monitor: registered state after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("count", int'(count), e.cnt);
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("underflow", int'(underflow), int'(e.udf));
            chk("cmp_match", int'(cmp_match), int'(e.cmp));
            chk("halted", int'(halted), int'(e.halt));
         end
      end
   end

   // monitor: combinational tick with the cycle's inputs applied
   initial begin
      bit t;
      forever begin
         @(negedge clk);
         #1;
         if (tq.size() > 0) begin
            t = tq.pop_front();
            chk("tick", int'(tick), int'(t));
         end
      end
   end

   initial begin
      @(negedge clk);
      rst = 1'b1;
      run(2);
      rst = 1'b0;

      // free-run overflow after 246 ticks from 10
      enable = 1'b1; cks = 3'd0; mode = 2'b00; up_down = 1'b1;
      compare = 8'd5; start_value = 8'd10; load = 1'b1;
      cyc();
      run(248);

      // down underflow, clear, clear colliding with a new underflow
      up_down = 1'b0; compare = 8'd100; start_value = 8'd3; load = 1'b1; clr_ovf = 1'b1; clr_cmp = 1'b1;
      cyc();
      run(4);
      clr_udf = 1'b1;
      cyc();
      run(1);
      start_value = 8'd0; load = 1'b1;
      cyc();
      clr_udf = 1'b1;
      cyc();
      run(2);

      // compare-reload 5..9
      mode = 2'b01; up_down = 1'b1; start_value = 8'd5; compare = 8'd9; load = 1'b1; clr_udf = 1'b1;
      cyc();
      run(8);

      // one-shot from 250, then reload resumes
      mode = 2'b10; start_value = 8'd250; compare = 8'd10; load = 1'b1; clr_cmp = 1'b1;
      cyc();
      run(10);
      clr_ovf = 1'b1; load = 1'b1;
      cyc();
      run(8);

      // prescaler divide by 4, enable hold, clamped cks
      mode = 2'b00; cks = 3'd2; start_value = 8'd0; compare = 8'd200; load = 1'b1; clr_ovf = 1'b1;
      cyc();
      run(12);
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(8);
      cks = 3'd7; load = 1'b1;
      cyc();
      run(40);

      // async reset with overflow pending
      cks = 3'd0; start_value = 8'd254; load = 1'b1;
      cyc();
      run(3);
      enable = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0; enable = 1'b1;

      // load in a tick cycle that would overflow
      start_value = 8'd255; load = 1'b1;
      cyc();
      start_value = 8'd7; load = 1'b1;
      cyc();
      run(3);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         enable  = ($urandom_range(0, 9) != 0);
         load    = ($urandom_range(0, 19) == 0);
         clr_ovf = ($urandom_range(0, 7) == 0);
         clr_udf = ($urandom_range(0, 7) == 0);
         clr_cmp = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) cks = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) up_down = 1'($urandom_range(0, 1));
         if (load) begin
            start_value = 8'($urandom_range(0, 255));
            compare     = 8'(int'(start_value) + $urandom_range(0, 12));
         end
         rst = ($urandom_range(0, 499) == 0);
         if (rst) enable = 1'b0;
         cyc();
      end
      rst = 1'b0; enable = 1'b0;
      run(2);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_counter_n.md
# timer_counter_n

Parametrised timer/counter: WIDTH-bit up/down counter with an internal power-of-two prescaler, three counting modes (free-run, compare-reload, one-shot), and sticky overflow/underflow/compare flags with individual clears. It is the generalised successor of the 8-bit timer counter and sits behind the timer register block, which drives its load, control and clear strobes and reads back the count and flags.

## Interface
- WIDTH, 8: counter and compare width.
- PSC_W, 4: prescaler width; maximum division is 2^PSC_W.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = prescaler and counter run; 0 = both hold.
- load  in  1  single-cycle strobe: count <= start_value, prescaler <= 0, halted <= 0.
- start_value  in  WIDTH  load and reload value.
- up_down  in  1  1 = count up, 0 = count down.
- mode  in  2  00 free-run, 01 compare-reload, 10 one-shot, 11 treated as 00.
- cks  in  3  prescale select n: tick every 2^n enabled cycles; n > PSC_W clamps to PSC_W.
- compare  in  WIDTH  compare value.
- clr_ovf, clr_udf, clr_cmp  in  1 each  clear strobes for the sticky flags.
- count  out  WIDTH  current count.
- tick  out  1  combinational; high in cycles where the counter advances.
- overflow, underflow, cmp_match  out  1 each  sticky event flags.
- halted  out  1  one-shot mode has terminated.

## Operation
- Prescaler: PSC_W-bit counter, increments when enable=1, cleared by load. tick = enable & ~halted & (cks==0 or low n prescaler bits all ones).
- Priority per cycle: rst > load > tick. Load in a tick cycle: the load is taken, no flag set.
- On tick, up: count==compare and mode=01 -> count <= start_value, set cmp_match; else count==2^WIDTH-1 -> count <= 0, set overflow; else count+1.
- On tick, down: count==compare and mode=01 -> count <= start_value, set cmp_match; else count==0 -> count <= 2^WIDTH-1, set underflow; else count-1.
- Modes 00/10: tick with count==compare sets cmp_match, no reload; wrap still applies.
- Mode 10: any overflow/underflow/cmp_match event also sets halted and loads count <= start_value; halted clears only on load or rst.
- Flags: set on event, cleared by the matching clr_*; simultaneous set and clear -> set wins.
- Changing mode, cks, up_down or compare mid-count takes effect from the next cycle; no other side effect.
- Arithmetic is modulo 2^WIDTH; compare is unsigned equality.

## Timing
- Reset values: count=0, prescaler=0, overflow=underflow=cmp_match=0, halted=0; tick=0 because enable is 0 during reset.
- count and flags are registered: visible one cycle after the tick/load edge.
- Load latency 1 cycle; first tick after load at cycle 2^n of enable (cks=n), or the next cycle when cks=0.
- Flag clear latency 1 cycle; rst deassertion is sampled on the next rising edge.
- rst asserted mid-count immediately forces all outputs to reset values.

## Structure
- Shared package timer_pkg: mode encodings (MODE_FREE, MODE_CMP, MODE_ONESHOT) and the cks width constant.
- Sub-module timer_prescaler (PSC_W, enable, load, cks -> tick); the top holds count, flags and halted.

## Test plan
- WIDTH=8, cks=0, mode=00, up, load 10 -> no flags for 245 ticks; on the 246th tick count=0 and overflow=1 one cycle later, underflow=0.
- Down from 3, mode=00 -> after 4 ticks count=255 and underflow=1; clr_udf -> underflow=0 the next cycle; clr_udf in the same cycle as a new underflow leaves underflow=1.
- mode=01, up, start 5, compare 9, cks=0 -> count sequence 5..9,5,6; cmp_match set on the 9->5 transition; overflow stays 0.
- mode=10, up, start 250 -> overflow, count=250 and halted=1 after 6 ticks; count holds afterwards; load clears halted and counting resumes.
- cks=2, enable=1 -> tick every 4th cycle; enable low for 3 cycles holds both the prescaler and count; cks=7 with PSC_W=4 gives a tick every 16 cycles.
- rst asserted mid-count with overflow set -> count and all flags are 0 asynchronously; load and tick in the same cycle -> count=start_value and no flag set.
